// File: rtl/morph_filter_nxn.sv
`default_nettype none
// ============================================================================
//  Module      : morph_filter_nxn
//  Description : KxK (K = 3 or 5) binary morphological filter for a 1-bit
//                pixel stream with vs/hs/clken framing. Modes: pass, erode,
//                dilate, majority. Fixed 3-cycle latency, sync delayed to
//                match. Optional foreground counter enabled by the macro
//                MORPH_STATS_EN (adds fg_count / fg_count_valid ports).
//  Revision    : 1.0  initial release
// ============================================================================
module morph_filter_nxn #(
    parameter int IMG_WIDTH  = 800,
    parameter int KSIZE      = 3,
    parameter bit BORDER_VAL = 1'b0,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pre_vs,
    input  logic             pre_hs,
    input  logic             pre_clken,
    input  logic             pre_imgbit,
    input  logic [1:0]       mode,
    output logic             post_vs,
    output logic             post_hs,
    output logic             post_clken,
    output logic             post_imgbit
`ifdef MORPH_STATS_EN
    ,
    output logic [CNT_W-1:0] fg_count,
    output logic             fg_count_valid
`endif
);

    localparam int c_radius  = (KSIZE - 1) / 2;
    localparam int c_nb      = KSIZE - 1;
    localparam int c_col_w   = $clog2(IMG_WIDTH + 1);
    localparam int c_addr_w  = $clog2(IMG_WIDTH);
    localparam int c_row_w   = $clog2(KSIZE);
    localparam int c_row_max = KSIZE - 1;
    localparam int c_maj     = (KSIZE * KSIZE) / 2;
    localparam int c_pc_w    = $clog2(KSIZE * KSIZE + 1);

    // Line buffers: lb_mem[j][c] holds the pixel j+1 rows above at column c.
    logic lb_mem [0:c_nb-1][0:IMG_WIDTH-1];

    // Front-end / datapath intermediates
    logic                  vs_rise;
    logic                  clken_fall;
    logic [c_col_w-1:0]    cur_col;
    logic [c_row_w-1:0]    cur_row;
    logic                  in_range;
    logic                  lb_we;
    logic [c_addr_w-1:0]   lb_addr;
    logic [c_nb-1:0]       lb_rd;
    logic [KSIZE-1:0]      new_col;
    logic [c_pc_w-1:0]     popcnt;
    logic                  result;

    // Registered state (_q) and next-state (_d)
    logic                  vs_prev_q, vs_prev_d;
    logic                  clken_prev_q, clken_prev_d;
    logic [c_col_w-1:0]    col_q, col_d;
    logic [c_row_w-1:0]    row_q, row_d;
    logic                  frame_ok_q, frame_ok_d;
    logic [1:0]            mode_q, mode_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_oob_q, s1_oob_d;
    logic                  s1_first_q, s1_first_d;
    logic                  s1_pix_q, s1_pix_d;
    logic [c_nb-1:0]       s1_lb_q, s1_lb_d;
    logic [c_row_w-1:0]    s1_row_q, s1_row_d;
    logic [1:0]            s1_mode_q, s1_mode_d;
    // win_q[j][k]: column age j (0 = newest), row offset k (0 = current row)
    logic [KSIZE-1:0][KSIZE-1:0] win_q, win_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_oob_q, s2_oob_d;
    logic [1:0]            s2_mode_q, s2_mode_d;
    logic                  vs_s1_q, vs_s1_d;
    logic                  vs_s2_q, vs_s2_d;
    logic                  hs_s1_q, hs_s1_d;
    logic                  hs_s2_q, hs_s2_d;
    logic                  post_vs_q, post_vs_d;
    logic                  post_hs_q, post_hs_d;
    logic                  post_clken_q, post_clken_d;
    logic                  post_imgbit_q, post_imgbit_d;

    // Line-buffer write: push the incoming pixel in, cascade older rows down.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_mem[0][lb_addr] <= pre_imgbit;
            for (int j = 1; j < c_nb; j++) begin
                lb_mem[j][lb_addr] <= lb_mem[j-1][lb_addr];
            end
        end
    end

    // Next-state logic for counters, the three pipeline stages and sync delay.
    always_comb begin
        // Frame/line edge detection; a frame start overrides stale counts.
        vs_rise    = pre_vs & ~vs_prev_q;
        clken_fall = clken_prev_q & ~pre_clken;
        cur_col    = vs_rise ? '0 : col_q;
        cur_row    = vs_rise ? '0 : row_q;
        in_range   = (cur_col < c_col_w'(IMG_WIDTH));
        lb_we      = pre_clken & in_range;
        lb_addr    = in_range ? cur_col[c_addr_w-1:0] : '0;
        for (int j = 0; j < c_nb; j++) begin
            lb_rd[j] = lb_mem[j][lb_addr];
        end

        vs_prev_d    = pre_vs;
        clken_prev_d = pre_clken;
        frame_ok_d   = frame_ok_q | vs_rise;
        mode_d       = vs_rise ? mode : mode_q;

        // Column saturates at IMG_WIDTH; row only needs to reach K-1 since
        // it is used solely to decide which window rows lie above the frame.
        col_d = cur_col;
        row_d = cur_row;
        if (pre_clken && in_range) begin
            col_d = cur_col + c_col_w'(1);
        end else if (clken_fall) begin
            col_d = '0;
            if (!vs_rise && (row_q < c_row_w'(c_row_max))) begin
                row_d = row_q + c_row_w'(1);
            end
        end

        // Stage 1: capture pixel, line-buffer column and position flags.
        s1_valid_d = pre_clken;
        s1_oob_d   = ~in_range;
        s1_first_d = (cur_col == '0);
        s1_pix_d   = pre_imgbit;
        s1_lb_d    = lb_rd;
        s1_row_d   = cur_row;
        s1_mode_d  = mode_d;

        // Stage 2: mask rows above the frame, shift the window on valid only.
        new_col[0] = s1_pix_q;
        for (int k = 1; k < KSIZE; k++) begin
            new_col[k] = (s1_row_q < c_row_w'(k)) ? BORDER_VAL : s1_lb_q[k-1];
        end
        win_d = win_q;
        if (s1_valid_q) begin
            win_d[0] = new_col;
            for (int j = 1; j < KSIZE; j++) begin
                // At column 0 every older column lies left of the frame.
                win_d[j] = s1_first_q ? {KSIZE{BORDER_VAL}} : win_q[j-1];
            end
        end
        s2_valid_d = s1_valid_q;
        s2_oob_d   = s1_oob_q;
        s2_mode_d  = s1_mode_q;

        // Stage 3: apply the selected operation to the settled window.
        popcnt = '0;
        for (int j = 0; j < KSIZE; j++) begin
            for (int k = 0; k < KSIZE; k++) begin
                popcnt = popcnt + c_pc_w'(win_q[j][k]);
            end
        end
        case (s2_mode_q)
            2'b00:   result = win_q[c_radius][c_radius];
            2'b01:   result = &win_q;
            2'b10:   result = |win_q;
            default: result = (popcnt > c_pc_w'(c_maj));
        endcase
        post_clken_d  = s2_valid_q & frame_ok_q;
        post_imgbit_d = s2_valid_q & frame_ok_q & (s2_oob_q ? BORDER_VAL : result);

        // Sync delay line, kept in step with the data pipeline.
        vs_s1_d   = pre_vs;
        vs_s2_d   = vs_s1_q;
        post_vs_d = vs_s2_q;
        hs_s1_d   = pre_hs;
        hs_s2_d   = hs_s1_q;
        post_hs_d = hs_s2_q;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q     <= 1'b0;
            clken_prev_q  <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            frame_ok_q    <= 1'b0;
            mode_q        <= 2'b00;
            s1_valid_q    <= 1'b0;
            s1_oob_q      <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_pix_q      <= 1'b0;
            s1_lb_q       <= '0;
            s1_row_q      <= '0;
            s1_mode_q     <= 2'b00;
            win_q         <= '0;
            s2_valid_q    <= 1'b0;
            s2_oob_q      <= 1'b0;
            s2_mode_q     <= 2'b00;
            vs_s1_q       <= 1'b0;
            vs_s2_q       <= 1'b0;
            hs_s1_q       <= 1'b0;
            hs_s2_q       <= 1'b0;
            post_vs_q     <= 1'b0;
            post_hs_q     <= 1'b0;
            post_clken_q  <= 1'b0;
            post_imgbit_q <= 1'b0;
        end else begin
            vs_prev_q     <= vs_prev_d;
            clken_prev_q  <= clken_prev_d;
            col_q         <= col_d;
            row_q         <= row_d;
            frame_ok_q    <= frame_ok_d;
            mode_q        <= mode_d;
            s1_valid_q    <= s1_valid_d;
            s1_oob_q      <= s1_oob_d;
            s1_first_q    <= s1_first_d;
            s1_pix_q      <= s1_pix_d;
            s1_lb_q       <= s1_lb_d;
            s1_row_q      <= s1_row_d;
            s1_mode_q     <= s1_mode_d;
            win_q         <= win_d;
            s2_valid_q    <= s2_valid_d;
            s2_oob_q      <= s2_oob_d;
            s2_mode_q     <= s2_mode_d;
            vs_s1_q       <= vs_s1_d;
            vs_s2_q       <= vs_s2_d;
            hs_s1_q       <= hs_s1_d;
            hs_s2_q       <= hs_s2_d;
            post_vs_q     <= post_vs_d;
            post_hs_q     <= post_hs_d;
            post_clken_q  <= post_clken_d;
            post_imgbit_q <= post_imgbit_d;
        end
    end

    assign post_vs     = post_vs_q;
    assign post_hs     = post_hs_q;
    assign post_clken  = post_clken_q;
    assign post_imgbit = post_imgbit_q;

`ifdef MORPH_STATS_EN
    logic             post_vs_prev_q, post_vs_prev_d;
    logic [CNT_W-1:0] fg_acc_q, fg_acc_d;
    logic [CNT_W-1:0] fg_count_q, fg_count_d;
    logic             fg_count_valid_q, fg_count_valid_d;
    logic             post_vs_rise;

    // Foreground accumulator: saturating count, reported and cleared at the
    // start of each output frame.
    always_comb begin
        post_vs_rise     = post_vs_q & ~post_vs_prev_q;
        post_vs_prev_d   = post_vs_q;
        fg_acc_d         = fg_acc_q;
        fg_count_d       = fg_count_q;
        fg_count_valid_d = post_vs_rise;
        if (post_vs_rise) begin
            fg_count_d = fg_acc_q;
            fg_acc_d   = '0;
        end else if (post_clken_q && post_imgbit_q && (fg_acc_q != {CNT_W{1'b1}})) begin
            fg_acc_d = fg_acc_q + CNT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_vs_prev_q   <= 1'b0;
            fg_acc_q         <= '0;
            fg_count_q       <= '0;
            fg_count_valid_q <= 1'b0;
        end else begin
            post_vs_prev_q   <= post_vs_prev_d;
            fg_acc_q         <= fg_acc_d;
            fg_count_q       <= fg_count_d;
            fg_count_valid_q <= fg_count_valid_d;
        end
    end

    assign fg_count       = fg_count_q;
    assign fg_count_valid = fg_count_valid_q;
`else
    // Counter width is only meaningful with statistics enabled.
    logic [CNT_W-1:0] stats_unused;
    assign stats_unused = '0;
`endif

endmodule
`default_nettype wire
